// File: rtl/note_pkg.sv
// Shared note-length definitions for the music path.
package note_pkg;

    localparam int unsigned NOTE_LEN_W       = 5;
    localparam int unsigned NUM_NOTE_LENS    = 32;
    localparam int unsigned NOTE_UNIT_CYCLES = 2083333;

    // Unit counter saturates one past the largest representable length so
    // overflow stays detectable without the count ever wrapping.
    localparam int unsigned UNIT_CNT_W = 6;
    localparam int unsigned UNIT_SAT   = NUM_NOTE_LENS + 1;

    typedef enum logic {
        IDLE,
        MEASURE
    } note_state_e;

endpackage

// File: rtl/note_unit_timer.sv
// Prescaler plus saturating unit counter for note-length measurement.
// With NOTE_LEN_ROUND_EN defined, also reports whether the residual
// prescaler count reaches half a unit.
module note_unit_timer
    import note_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = NOTE_UNIT_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_start,
    input  logic                  i_count,
    output logic [UNIT_CNT_W-1:0] o_units
`ifdef NOTE_LEN_ROUND_EN
    ,
    output logic                  o_ge_half_c
`endif
);

    localparam int unsigned PRESC_W = $clog2(UNIT_CYCLES);

    logic [PRESC_W-1:0] presc;

    // Start loads a count of one: the edge that detects the rise is itself
    // a high sample of the press.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            presc   <= '0;
            o_units <= '0;
        end else if (i_start) begin
            presc   <= PRESC_W'(1);
            o_units <= '0;
        end else if (i_count) begin
            if (presc == PRESC_W'(UNIT_CYCLES - 1)) begin
                presc <= '0;
                if (o_units != UNIT_CNT_W'(UNIT_SAT)) begin
                    o_units <= o_units + UNIT_CNT_W'(1);
                end
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

`ifdef NOTE_LEN_ROUND_EN
    // Round half-up: residual r rounds up when r + floor(U/2) >= U,
    // i.e. r >= U - floor(U/2) (equals floor(U/2) for even U).
    localparam int unsigned HALF = UNIT_CYCLES - (UNIT_CYCLES / 2);

    // Residual reaches the round-up threshold.
    always_comb begin
        o_ge_half_c = (presc >= PRESC_W'(HALF));
    end
`endif

endmodule

// File: rtl/note_length_capture.sv
// Note gate duration capture: measures how long i_gate is held and emits
// the 5-bit note-length code, (code + 1) * UNIT_CYCLES ~= held cycles.
// Build option: NOTE_LEN_ROUND_EN selects round-half-up, otherwise truncate.
module note_length_capture
    import note_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = NOTE_UNIT_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_gate,
    output logic                  o_valid,
    output logic [NOTE_LEN_W-1:0] o_note_len,
    output logic                  o_overflow,
    output logic                  o_busy
);

    note_state_e state, state_nxt;

    logic                  r_gate;
    logic                  rise_c;
    logic                  fall_c;
    logic                  timer_clear;
    logic                  timer_start;
    logic                  timer_count;
    logic [UNIT_CNT_W-1:0] timer_units;
    logic [UNIT_CNT_W-1:0] units_r;
    logic [NOTE_LEN_W-1:0] code_c;
    logic                  ovf_c;
    logic                  valid_nxt;
    logic [NOTE_LEN_W-1:0] len_nxt;
    logic                  ovf_nxt;
    logic                  busy_nxt;

`ifdef NOTE_LEN_ROUND_EN
    logic                  timer_half_c;
`endif

    // Gate history; resets high so a gate held through reset is ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gate <= 1'b1;
        end else begin
            r_gate <= i_gate;
        end
    end

    // Edge detection.
    always_comb begin
        rise_c = i_gate & ~r_gate;
        fall_c = ~i_gate & r_gate;
    end

    note_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (timer_clear),
        .i_start     (timer_start),
        .i_count     (timer_count),
        .o_units     (timer_units)
`ifdef NOTE_LEN_ROUND_EN
        ,
        .o_ge_half_c (timer_half_c)
`endif
    );

    // Quantise measured units into a clamped length code.
    always_comb begin
        units_r = timer_units;
`ifdef NOTE_LEN_ROUND_EN
        units_r = timer_units + UNIT_CNT_W'(timer_half_c);
`endif
        ovf_c  = 1'b0;
        code_c = '0;
        if (units_r > UNIT_CNT_W'(NUM_NOTE_LENS)) begin
            ovf_c  = 1'b1;
            code_c = NOTE_LEN_W'(NUM_NOTE_LENS - 1);
        end else if (units_r != '0) begin
            code_c = NOTE_LEN_W'(units_r - UNIT_CNT_W'(1));
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            o_valid    <= 1'b0;
            o_note_len <= '0;
            o_overflow <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_valid    <= valid_nxt;
            o_note_len <= len_nxt;
            o_overflow <= ovf_nxt;
            o_busy     <= busy_nxt;
        end
    end

    // Next-state, timer control and next-output logic.
    always_comb begin
        state_nxt   = state;
        valid_nxt   = 1'b0;
        len_nxt     = o_note_len;
        ovf_nxt     = o_overflow;
        timer_clear = 1'b0;
        timer_start = 1'b0;
        timer_count = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise_c) begin
                    state_nxt   = MEASURE;
                    timer_start = 1'b1;
                end
            end
            MEASURE: begin
                if (fall_c) begin
                    state_nxt   = IDLE;
                    timer_clear = 1'b1;
                    valid_nxt   = 1'b1;
                    len_nxt     = code_c;
                    ovf_nxt     = ovf_c;
                end else if (i_gate) begin
                    timer_count = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt == MEASURE);
    end

endmodule

// File: tb/tb_note_length_capture.sv
// Self-checking bench for note_length_capture with UNIT_CYCLES = 8.
// Expected codes come from a reference formula pushed into a scoreboard
// queue as each press is driven, and are popped when o_valid appears.
module tb_note_length_capture;

    localparam int unsigned U = 8;

    typedef struct packed {
        logic [4:0] len;
        logic       ovf;
    } res_t;

    logic       clk;
    logic       rst;
    logic       gate;
    logic       o_valid;
    logic [4:0] o_note_len;
    logic       o_overflow;
    logic       o_busy;

    int   vectors;
    int   miscompares;
    res_t exp_q[$];

    note_length_capture #(
        .UNIT_CYCLES (U)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_gate     (gate),
        .o_valid    (o_valid),
        .o_note_len (o_note_len),
        .o_overflow (o_overflow),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: R from the held-sample count, then clamp(R-1, 0, 31).
    function automatic res_t model(input int c);
        res_t r;
        int   units;
`ifdef NOTE_LEN_ROUND_EN
        units = (c + int'(U / 2)) / int'(U);
`else
        units = c / int'(U);
`endif
        r.ovf = (units > 32);
        if (units == 0)      r.len = 5'd0;
        else if (units > 32) r.len = 5'd31;
        else                 r.len = 5'(units - 1);
        return r;
    endfunction

    // Stimulus: hold gate for exactly c sampling edges; call just after a negedge.
    task automatic press(input int c);
        exp_q.push_back(model(c));
        gate = 1'b1;
        repeat (c) @(negedge clk);
        gate = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for the next o_valid and returns what the DUT showed.
    task automatic collect(output bit found, output int lat,
                           output logic [4:0] len, output logic ovf);
        found = 1'b0;
        lat   = 0;
        len   = '0;
        ovf   = 1'b0;
        for (int i = 1; i <= 50 && !found; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                found = 1'b1;
                lat   = i;
                len   = o_note_len;
                ovf   = o_overflow;
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        gate = 1'b0;
        idle(3);
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 0", o_valid);
        end
        vectors++;
        if (o_note_len !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_len: got %0d want 0", o_note_len);
        end
        vectors++;
        if (o_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ovf: got %b want 0", o_overflow);
        end
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", o_busy);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        bit         found;
        int         lat;
        logic [4:0] len;
        logic       ovf;
        res_t       e;
        exp_q.push_back(model(12));
        gate = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy_rise: got %b want 1", o_busy);
        end
        repeat (11) @(negedge clk);
        gate = 1'b0;
        collect(found, lat, len, ovf);
        e = exp_q.pop_front();
        vectors++;
        if (!found || lat != 1) begin
            miscompares++;
            $display("FAIL basic_latency: found=%0b lat=%0d want lat 1", found, lat);
        end
        vectors++;
        if (len !== e.len || ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL basic_code: got %0d/%b want %0d/%b", len, ovf, e.len, e.ovf);
        end
        @(negedge clk);
        vectors++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_after: valid=%b busy=%b want 0/0", o_valid, o_busy);
        end
        idle(2);
    endtask

    // Presses at the rounding and overflow boundaries, plus random lengths.
    task automatic test_lengths(input string name, input int n, input int fixed[4]);
        bit         found;
        int         lat;
        int         c;
        logic [4:0] len;
        logic       ovf;
        res_t       e;
        for (int k = 0; k < n; k++) begin
            c = (fixed[k] > 0) ? fixed[k] : int'($urandom_range(1, 80));
            press(c);
            collect(found, lat, len, ovf);
            e = exp_q.pop_front();
            vectors++;
            if (!found || lat != 1 || len !== e.len || ovf !== e.ovf) begin
                miscompares++;
                $display("FAIL %s_c%0d: found=%0b lat=%0d got %0d/%b want %0d/%b",
                         name, c, found, lat, len, ovf, e.len, e.ovf);
            end
            idle(2);
        end
    endtask

    task automatic test_reset_mid_press();
        bit seen;
        gate = 1'b1;
        idle(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_note_len !== 5'd0 || o_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: busy=%b valid=%b len=%0d ovf=%b want all 0",
                     o_busy, o_valid, o_note_len, o_overflow);
        end
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1 || o_busy === 1'b1) seen = 1'b1;
        end
        gate = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1 || o_busy === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL midreset_no_capture: got activity want none");
        end
    endtask

    task automatic test_gate_through_reset();
        bit         seen;
        bit         found;
        int         lat;
        logic [4:0] len;
        logic       ovf;
        res_t       e;
        gate = 1'b1;
        rst  = 1'b1;
        idle(2);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1 || o_busy === 1'b1) seen = 1'b1;
        end
        gate = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1 || o_busy === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL held_reset_ignored: got activity want none");
        end
        press(12);
        collect(found, lat, len, ovf);
        e = exp_q.pop_front();
        vectors++;
        if (!found || lat != 1 || len !== e.len || ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL held_reset_next: found=%0b lat=%0d got %0d/%b want %0d/%b",
                     found, lat, len, ovf, e.len, e.ovf);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        bit         found;
        int         lat;
        logic [4:0] len;
        logic       ovf;
        res_t       e;
        exp_q.push_back(model(16));
        exp_q.push_back(model(24));
        gate = 1'b1;
        idle(16);
        gate = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (o_valid !== 1'b1 || o_note_len !== e.len || o_overflow !== e.ovf) begin
            miscompares++;
            $display("FAIL b2b_first: valid=%b got %0d/%b want 1 %0d/%b",
                     o_valid, o_note_len, o_overflow, e.len, e.ovf);
        end
        gate = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_busy: busy=%b valid=%b want 1/0", o_busy, o_valid);
        end
        idle(23);
        gate = 1'b0;
        collect(found, lat, len, ovf);
        e = exp_q.pop_front();
        vectors++;
        if (!found || lat != 1 || len !== e.len || ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL b2b_second: found=%0b lat=%0d got %0d/%b want %0d/%b",
                     found, lat, len, ovf, e.len, e.ovf);
        end
        idle(2);
    endtask

    task automatic test_min_press();
        bit         found;
        int         lat;
        logic [4:0] len;
        logic       ovf;
        res_t       e;
        press(1);
        collect(found, lat, len, ovf);
        e = exp_q.pop_front();
        vectors++;
        if (!found || lat != 1 || len !== e.len || ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL min_press: found=%0b lat=%0d got %0d/%b want %0d/%b",
                     found, lat, len, ovf, e.len, e.ovf);
        end
        idle(10);
        vectors++;
        if (o_note_len !== 5'd0 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL min_hold: len=%0d valid=%b want 0/0", o_note_len, o_valid);
        end
    endtask

    initial begin
        int rounding[4];
        int overflow[4];
        int randoms[4];
        vectors     = 0;
        miscompares = 0;
        rounding    = '{11, 12, 4, 3};
        overflow    = '{300, 256, 264, 263};
        randoms     = '{0, 0, 0, 0};
        rst  = 1'b1;
        gate = 1'b0;

        test_reset();
        test_basic();
        test_lengths("rounding", 4, rounding);
        test_lengths("overflow", 4, overflow);
        test_reset_mid_press();
        test_gate_through_reset();
        test_back_to_back();
        test_min_press();
        test_lengths("random", 4, randoms);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
